// File: rtl/button_conditioner_if.sv
// Signal bundle between the raw labkit buttons / blink control and the conditioner.
// The slave side is the conditioner; the master side drives buttons and reads results.
interface button_conditioner_if;
  logic       btn_up_n;
  logic       btn_down_n;
  logic       btn_left_n;
  logic       btn_right_n;
  logic       blink_restart;
  logic       b_up;
  logic       b_down;
  logic       b_left;
  logic       b_right;
  logic       blink_fo;
  logic [1:0] up_state;
  logic [1:0] down_state;

  // No handshake: raw buttons are free-running levels, blink_restart is a
  // one-cycle strobe, and every output is a level valid on every cycle.
  modport master (
    output btn_up_n, btn_down_n, btn_left_n, btn_right_n, blink_restart,
    input  b_up, b_down, b_left, b_right, blink_fo, up_state, down_state
  );

  modport slave (
    input  btn_up_n, btn_down_n, btn_left_n, btn_right_n, blink_restart,
    output b_up, b_down, b_left, b_right, blink_fo, up_state, down_state
  );
endinterface

// File: rtl/button_conditioner.sv
// Synchronizes and debounces four active-low buttons, adds hold-then-repeat to
// up/down, and generates the cursor blink square wave.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 650000,
  parameter int HOLD_CYCLES     = 13500000,
  parameter int REPEAT_CYCLES   = 2700000,
  parameter int BLINK_HALF      = 6750000
) (
  input  logic                 clk,
  input  logic                 reset,
  button_conditioner_if.slave  bus
);

  localparam int DB_W   = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HR_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int HR_W   = (HR_MAX > 2) ? $clog2(HR_MAX) : 1;
  localparam int BL_W   = (BLINK_HALF > 2) ? $clog2(BLINK_HALF) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } rep_state_t;

  // Bit order everywhere: 0 up, 1 down, 2 left, 3 right.
  logic [3:0]      raw_n;
  logic [3:0]      sync1;
  logic [3:0]      sync2;
  logic [3:0]      level;
  logic [3:0]      deb;
  logic [DB_W-1:0] db_cnt [4];

  assign raw_n = {bus.btn_right_n, bus.btn_left_n, bus.btn_down_n, bus.btn_up_n};
  assign level = ~sync2;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '1;
      sync2 <= '1;
      deb   <= '0;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= raw_n;
      sync2 <= sync1;
      for (int i = 0; i < 4; i++) begin
        if (level[i] == deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          deb[i]    <= level[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Auto-repeat for up (0) and down (1); the output is gated by the debounced
  // level so a release drops it on the same cycle the FSM is sent to IDLE.
  rep_state_t      st     [2];
  rep_state_t      st_nxt [2];
  logic [HR_W-1:0] hr_cnt     [2];
  logic [HR_W-1:0] hr_cnt_nxt [2];
  logic [1:0]      rep_out;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        st[i]     <= ST_IDLE;
        hr_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        st[i]     <= st_nxt[i];
        hr_cnt[i] <= hr_cnt_nxt[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      st_nxt[i]     = st[i];
      hr_cnt_nxt[i] = hr_cnt[i];
      rep_out[i]    = 1'b0;
      if (!deb[i]) begin
        st_nxt[i]     = ST_IDLE;
        hr_cnt_nxt[i] = '0;
      end else begin
        case (st[i])
          ST_IDLE: begin
            rep_out[i]    = 1'b1;
            st_nxt[i]     = ST_HOLD;
            hr_cnt_nxt[i] = '0;
          end
          ST_HOLD: begin
            rep_out[i] = 1'b1;
            if (hr_cnt[i] == HR_W'(HOLD_CYCLES - 1)) begin
              st_nxt[i]     = ST_REPEAT;
              hr_cnt_nxt[i] = '0;
            end else begin
              hr_cnt_nxt[i] = hr_cnt[i] + 1'b1;
            end
          end
          ST_REPEAT: begin
            if (hr_cnt[i] == HR_W'(REPEAT_CYCLES - 1)) begin
              rep_out[i]    = 1'b0;
              hr_cnt_nxt[i] = '0;
            end else begin
              rep_out[i]    = 1'b1;
              hr_cnt_nxt[i] = hr_cnt[i] + 1'b1;
            end
          end
          default: begin
            st_nxt[i]     = ST_IDLE;
            hr_cnt_nxt[i] = '0;
          end
        endcase
      end
    end
  end

  logic [BL_W-1:0] blink_cnt;
  logic            blink_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt <= '0;
      blink_q   <= 1'b0;
    end else if (bus.blink_restart) begin
      blink_cnt <= '0;
      blink_q   <= 1'b1;
    end else if (blink_cnt == BL_W'(BLINK_HALF - 1)) begin
      blink_cnt <= '0;
      blink_q   <= ~blink_q;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  assign bus.b_up       = rep_out[0];
  assign bus.b_down     = rep_out[1];
  assign bus.b_left     = deb[2];
  assign bus.b_right    = deb[3];
  assign bus.blink_fo   = blink_q;
  assign bus.up_state   = st[0];
  assign bus.down_state = st[1];

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with small timing parameters
// (debounce 4, hold 10, repeat 3, blink half-period 5).
module tb_button_conditioner;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  button_conditioner_if bus ();

  button_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES    (10),
    .REPEAT_CYCLES  (3),
    .BLINK_HALF     (5)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic check_st(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Expected up/down output k edges after a press (raw low before edge 1):
  // debounced at 6, HOLD on edges 7..16, REPEAT from 17 with low pulses on
  // 19, 22, 25, ...; a release after edge rel drops it from edge rel+6.
  function automatic logic exp_rep(input int k, input int rel);
    if (rel != 0 && k >= rel + 6) return 1'b0;
    if (k < 6) return 1'b0;
    if (k >= 19 && ((k - 19) % 3) == 0) return 1'b0;
    return 1'b1;
  endfunction

  initial begin
    reset             = 1'b1;
    bus.btn_up_n      = 1'b1;
    bus.btn_down_n    = 1'b1;
    bus.btn_left_n    = 1'b1;
    bus.btn_right_n   = 1'b1;
    bus.blink_restart = 1'b0;
    tick(3);
    check("rst_b_up", bus.b_up, 1'b0);
    check("rst_b_down", bus.b_down, 1'b0);
    check("rst_b_left", bus.b_left, 1'b0);
    check("rst_b_right", bus.b_right, 1'b0);
    check("rst_blink", bus.blink_fo, 1'b0);
    check_st("rst_up_state", bus.up_state, 2'd0);
    reset = 1'b0;

    // Blink: 0 for 5 cycles, then toggles every 5.
    tick(4); check("blink_c4", bus.blink_fo, 1'b0);
    tick(1); check("blink_c5", bus.blink_fo, 1'b1);
    tick(4); check("blink_c9", bus.blink_fo, 1'b1);
    tick(1); check("blink_c10", bus.blink_fo, 1'b0);
    // Counter=4 with blink high: a plain wrap would drop it, restart keeps it.
    tick(9); check("blink_pre_restart", bus.blink_fo, 1'b1);
    bus.blink_restart = 1'b1;
    tick(1);
    bus.blink_restart = 1'b0;
    check("blink_restart", bus.blink_fo, 1'b1);
    tick(4); check("blink_restart_p4", bus.blink_fo, 1'b1);
    tick(1); check("blink_restart_p5", bus.blink_fo, 1'b0);

    // Left held, 3-cycle glitch on right.
    bus.btn_left_n  = 1'b0;
    bus.btn_right_n = 1'b0;
    tick(3);
    bus.btn_right_n = 1'b1;
    tick(2);
    check("left_c5", bus.b_left, 1'b0);
    check("right_glitch_c5", bus.b_right, 1'b0);
    tick(1);
    check("left_c6", bus.b_left, 1'b1);
    check("right_glitch_c6", bus.b_right, 1'b0);
    tick(4);
    check("right_glitch_c10", bus.b_right, 1'b0);
    bus.btn_left_n = 1'b1;
    tick(5); check("left_rel_c5", bus.b_left, 1'b1);
    tick(1); check("left_rel_c6", bus.b_left, 1'b0);

    // 4-cycle low on right is just long enough to pass.
    bus.btn_right_n = 1'b0;
    tick(4);
    bus.btn_right_n = 1'b1;
    tick(1); check("right4_c5", bus.b_right, 1'b0);
    tick(1); check("right4_c6", bus.b_right, 1'b1);
    tick(3); check("right4_c9", bus.b_right, 1'b1);
    tick(1); check("right4_c10", bus.b_right, 1'b0);

    // Up and down pressed together, released after edge 27.
    bus.btn_up_n   = 1'b0;
    bus.btn_down_n = 1'b0;
    for (int k = 1; k <= 35; k++) begin
      tick(1);
      check($sformatf("both_up_k%0d", k), bus.b_up, exp_rep(k, 27));
      check($sformatf("both_down_k%0d", k), bus.b_down, exp_rep(k, 27));
      if (k == 6)  check_st("up_state_idle_k6", bus.up_state, 2'd0);
      if (k == 7)  check_st("up_state_hold_k7", bus.up_state, 2'd1);
      if (k == 17) check_st("down_state_rep_k17", bus.down_state, 2'd2);
      if (k == 34) check_st("up_state_rel_k34", bus.up_state, 2'd0);
      if (k == 27) begin
        bus.btn_up_n   = 1'b1;
        bus.btn_down_n = 1'b1;
      end
    end

    // Reset in REPEAT with up still held, then a full re-debounce and hold.
    bus.btn_up_n = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick(1);
      check($sformatf("pre_rst_up_k%0d", k), bus.b_up, exp_rep(k, 0));
    end
    check_st("pre_rst_state", bus.up_state, 2'd2);
    reset = 1'b1;
    tick(1);
    check("mid_rst_b_up", bus.b_up, 1'b0);
    check_st("mid_rst_state", bus.up_state, 2'd0);
    reset = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick(1);
      check($sformatf("post_rst_up_k%0d", k), bus.b_up, exp_rep(k, 0));
    end
    bus.btn_up_n = 1'b1;
    tick(8);
    check("final_b_up", bus.b_up, 1'b0);
    check("final_b_down", bus.b_down, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
